// File: rtl/logicnets_input_packer.sv
// LogicNets input packer: quantizes a stream of signed samples to small
// unsigned codes and assembles them into double-buffered packed frames.
module logicnets_input_packer #(
    parameter int unsigned SAMPLE_W     = 16,
    parameter int unsigned NUM_FEATURES = 8,
    parameter int unsigned CODE_W       = 2,
    parameter int unsigned SHIFT        = 12,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [SAMPLE_W-1:0]            in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_FEATURES*CODE_W-1:0] out_data,
    output logic                           err_frame,
    output logic [CNT_W-1:0]               frame_count
);

    localparam int unsigned DATA_W   = NUM_FEATURES * CODE_W;
    localparam int unsigned IDX_W    = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam int unsigned EXT_W    = SAMPLE_W + 1;
    localparam int unsigned HALF     = 1 << (CODE_W - 1);
    localparam int unsigned CODE_MAX = (1 << CODE_W) - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FULL    = 2'd1,
        RESYNC  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic [IDX_W-1:0]        index;
    logic [IDX_W-1:0]        index_d;
    logic [DATA_W-1:0]       cbuf;
    logic [DATA_W-1:0]       cbuf_next;
    logic                    err_d;
    logic                    buf_wr;
    logic                    load_new;
    logic                    load_pending;

    logic                    accept;
    logic                    out_fire;
    logic                    slot_free;
    logic                    at_last;

    logic signed [EXT_W-1:0] s_ext;
    logic signed [EXT_W-1:0] s_shr;
    logic signed [EXT_W-1:0] q_sum;
    logic [CODE_W-1:0]       code;

    assign accept    = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign slot_free = ~out_valid | out_ready;
    assign at_last   = (index == LAST_IDX);

    // Quantizer: arithmetic shift, re-center around mid-code, saturate.
    always_comb begin
        s_ext = {in_data[SAMPLE_W-1], in_data};
        s_shr = s_ext >>> SHIFT;
        q_sum = s_shr + $signed(EXT_W'(HALF));
        code  = q_sum[CODE_W-1:0];
        if (q_sum[EXT_W-1]) begin
            code = '0;
        end else if (q_sum[EXT_W-2:0] > (EXT_W-1)'(CODE_MAX)) begin
            code = CODE_W'(CODE_MAX);
        end
    end

    // Collect buffer with the incoming code merged into the current slot.
    always_comb begin
        cbuf_next = cbuf;
        for (int i = 0; i < int'(NUM_FEATURES); i++) begin
            if (index == IDX_W'(i)) begin
                cbuf_next[i*CODE_W +: CODE_W] = code;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_d;
        end
    end

    // Next-state, slot index and buffer-transfer decisions.
    always_comb begin
        state_d      = state;
        index_d      = index;
        err_d        = 1'b0;
        buf_wr       = 1'b0;
        load_new     = 1'b0;
        load_pending = 1'b0;
        case (state)
            COLLECT: begin
                if (accept) begin
                    buf_wr = 1'b1;
                    if (!at_last) begin
                        if (in_last) begin
                            err_d   = 1'b1;
                            index_d = '0;
                        end else begin
                            index_d = index + IDX_W'(1);
                        end
                    end else begin
                        index_d = '0;
                        if (!in_last) begin
                            err_d   = 1'b1;
                            state_d = RESYNC;
                        end else if (slot_free) begin
                            load_new = 1'b1;
                        end else begin
                            state_d = FULL;
                        end
                    end
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_pending = 1'b1;
                    index_d      = '0;
                    state_d      = COLLECT;
                end
            end
            RESYNC: begin
                if (accept && in_last) begin
                    index_d = '0;
                    state_d = COLLECT;
                end
            end
            default: begin
                index_d = '0;
                state_d = COLLECT;
            end
        endcase
    end

    // Slot index and collect buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index <= '0;
            cbuf  <= '0;
        end else begin
            index <= index_d;
            if (buf_wr) begin
                cbuf <= cbuf_next;
            end
        end
    end

    // Output slot: loaded from the finishing frame or from the pending buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (load_new) begin
                out_valid <= 1'b1;
                out_data  <= cbuf_next;
            end else if (load_pending) begin
                out_valid <= 1'b1;
                out_data  <= cbuf;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Registered ready, error pulse and delivered-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready    <= 1'b0;
            err_frame   <= 1'b0;
            frame_count <= '0;
        end else begin
            in_ready  <= (state_d != FULL);
            err_frame <= err_d;
            if (out_fire) begin
                frame_count <= frame_count + CNT_W'(1);
            end
        end
    end

endmodule
